// File: rtl/my9262_rx.sv
// MY9262 serial-interface receiver: synchronises LAT/DCLK/DI, shifts DI
// MSB-first on DCLK rises, emits 16-bit words and classifies LAT pulses.
module my9262_rx #(
    parameter int unsigned CFG_EDGES   = 11,
    parameter int unsigned GLB_EDGES   = 3,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        CLK_200M,
    input  logic        RST_N,
    input  logic        rx_Lat,
    input  logic        rx_Dclk,
    input  logic        rx_Di,
    output logic [15:0] rx_Word,
    output logic        rx_Word_Valid,
    output logic [1:0]  rx_Cmd,
    output logic        rx_Cmd_Valid,
    output logic [4:0]  rx_Lat_Edges,
    output logic [9:0]  rx_Frame_Bits,
    output logic [15:0] rx_Frame_Word,
    output logic        rx_Err
);

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned WCNT_W  = 4;
    localparam int unsigned FRAME_W = 10;
    localparam int unsigned LAT_W   = 5;
    localparam int unsigned IDLE_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] CMD_DATA = 2'd0;
    localparam logic [1:0] CMD_GLB  = 2'd1;
    localparam logic [1:0] CMD_CFG  = 2'd2;
    localparam logic [1:0] CMD_UNK  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        LATCH  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic lat_s1, lat_s2, lat_s3;
    logic dclk_s1, dclk_s2, dclk_s3;
    logic di_s1, di_s2;

    logic [WORD_W-1:0]  shift;
    logic [WCNT_W-1:0]  word_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [IDLE_W-1:0]  idle_cnt;

    logic dclk_rise, lat_rise, lat_fall;
    logic [WORD_W-1:0]  shift_nxt, shift_now;
    logic [FRAME_W-1:0] frame_inc, frame_now;
    logic [1:0]         cmd_c;
    logic               report_c;
    logic               timeout_c;

    assign dclk_rise = dclk_s2 & ~dclk_s3;
    assign lat_rise  = lat_s2 & ~lat_s3;
    assign lat_fall  = ~lat_s2 & lat_s3;

    // Shift value, saturated frame count, and their values including this cycle's rise
    assign shift_nxt = {shift[WORD_W-2:0], di_s2};
    assign frame_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + FRAME_W'(1);
    assign shift_now = dclk_rise ? shift_nxt : shift;
    assign frame_now = dclk_rise ? frame_inc : frame_cnt;

    // Command classification from the LAT-high edge count
    always_comb begin
        cmd_c = CMD_UNK;
        if (lat_cnt == LAT_W'(CFG_EDGES))
            cmd_c = CMD_CFG;
        else if (lat_cnt == LAT_W'(GLB_EDGES))
            cmd_c = CMD_GLB;
        else if (lat_cnt == '0)
            cmd_c = CMD_DATA;
    end

    // Pin synchronisers plus edge-detect stage
    always_ff @(posedge CLK_200M or negedge RST_N) begin
        if (!RST_N) begin
            lat_s1  <= 1'b0; lat_s2  <= 1'b0; lat_s3  <= 1'b0;
            dclk_s1 <= 1'b0; dclk_s2 <= 1'b0; dclk_s3 <= 1'b0;
            di_s1   <= 1'b0; di_s2   <= 1'b0;
        end else begin
            lat_s1  <= rx_Lat;  lat_s2  <= lat_s1;  lat_s3  <= lat_s2;
            dclk_s1 <= rx_Dclk; dclk_s2 <= dclk_s1; dclk_s3 <= dclk_s2;
            di_s1   <= rx_Di;   di_s2   <= di_s1;
        end
    end

    // FSM state register
    always_ff @(posedge CLK_200M or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state and frame-event decode
    always_comb begin
        state_nxt = state;
        report_c  = 1'b0;
        timeout_c = 1'b0;
        case (state)
            IDLE: begin
                if (lat_rise)
                    state_nxt = LATCH;
                else if (dclk_rise)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                if (lat_rise) begin
                    state_nxt = LATCH;
                end else if (!dclk_rise && idle_cnt == IDLE_W'(TIMEOUT_CYC)) begin
                    timeout_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            LATCH: begin
                if (lat_fall) begin
                    report_c  = 1'b1;
                    state_nxt = REPORT;
                end
            end
            REPORT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, word/frame counters; timeout discards the partial frame
    always_ff @(posedge CLK_200M or negedge RST_N) begin
        if (!RST_N) begin
            shift     <= '0;
            word_cnt  <= '0;
            frame_cnt <= '0;
        end else if (timeout_c) begin
            shift     <= '0;
            word_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            if (dclk_rise)
                shift <= shift_nxt;
            if (state == REPORT) begin
                word_cnt  <= '0;
                frame_cnt <= '0;
            end else if (dclk_rise) begin
                word_cnt  <= word_cnt + WCNT_W'(1);
                frame_cnt <= frame_inc;
            end
        end
    end

    // LAT-high edge counter; a rise in the lat_rise cycle already counts
    always_ff @(posedge CLK_200M or negedge RST_N) begin
        if (!RST_N)
            lat_cnt <= '0;
        else if (lat_rise)
            lat_cnt <= dclk_rise ? LAT_W'(1) : '0;
        else if (dclk_rise && lat_s2 && lat_cnt != '1)
            lat_cnt <= lat_cnt + LAT_W'(1);
    end

    // Cycles since the last DCLK rise while in SHIFT
    always_ff @(posedge CLK_200M or negedge RST_N) begin
        if (!RST_N)
            idle_cnt <= '0;
        else if (state != SHIFT || dclk_rise)
            idle_cnt <= '0;
        else if (idle_cnt != '1)
            idle_cnt <= idle_cnt + IDLE_W'(1);
    end

    // Registered outputs and strobes
    always_ff @(posedge CLK_200M or negedge RST_N) begin
        if (!RST_N) begin
            rx_Word       <= '0;
            rx_Word_Valid <= 1'b0;
            rx_Cmd        <= '0;
            rx_Cmd_Valid  <= 1'b0;
            rx_Lat_Edges  <= '0;
            rx_Frame_Bits <= '0;
            rx_Frame_Word <= '0;
            rx_Err        <= 1'b0;
        end else begin
            rx_Word_Valid <= 1'b0;
            rx_Cmd_Valid  <= 1'b0;
            rx_Err        <= 1'b0;
            if (dclk_rise && word_cnt == '1) begin
                rx_Word       <= shift_nxt;
                rx_Word_Valid <= 1'b1;
            end
            if (report_c) begin
                rx_Cmd_Valid  <= 1'b1;
                rx_Cmd        <= cmd_c;
                rx_Lat_Edges  <= lat_cnt;
                rx_Frame_Bits <= frame_now;
                rx_Frame_Word <= shift_now;
                rx_Err        <= (cmd_c == CMD_UNK);
            end
            if (timeout_c)
                rx_Err <= 1'b1;
        end
    end

endmodule

// File: doc/my9262_rx.md
Name: my9262_rx

Overview:
- Receive-side decoder for the MY9262 LED-driver serial interface (LAT/DCLK/DI).
- Samples the three pins, which are asynchronous to CLK_200M, and shifts DI MSB-first on each DCLK rising edge.
- Emits the 16-bit words it receives and classifies each LAT pulse by the number of DCLK rising edges seen while LAT is high.
- Used as the on-chip loopback monitor for the MY9262 transmitter, and as a chain emulator in board bring-up.

Parameters:
- CFG_EDGES, 11, DCLK rising edges during LAT-high that identify a configuration-register write.
- GLB_EDGES, 3, DCLK rising edges during LAT-high that identify a global latch.
- TIMEOUT_CYC, 1023, CLK_200M cycles with no DCLK rise (LAT low, frame non-empty) before the partial frame is discarded.

Ports:
- CLK_200M  input  1  system clock.
- RST_N  input  1  asynchronous, active-low reset.
- rx_Lat  input  1  LAT pin, asynchronous.
- rx_Dclk  input  1  DCLK pin, asynchronous.
- rx_Di  input  1  DI pin, asynchronous.
- rx_Word  output  16  last completed 16-bit word, MSB = first bit received.
- rx_Word_Valid  output  1  one-cycle strobe; rx_Word is updated in the same cycle.
- rx_Cmd  output  2  0 = data latch, 1 = global latch, 2 = config, 3 = unknown.
- rx_Cmd_Valid  output  1  one-cycle strobe at end of each LAT pulse.
- rx_Lat_Edges  output  5  DCLK rises counted during the last LAT pulse; saturates at 31.
- rx_Frame_Bits  output  10  DCLK rises since the previous LAT fall, including rises during LAT; saturates at 1023.
- rx_Frame_Word  output  16  shift-register contents at LAT fall.
- rx_Err  output  1  one-cycle strobe: unknown command or timeout.

Behaviour:
- Reset: every output is 0; the shift register, all counters and the synchroniser flops are 0; FSM = IDLE.
- Reset asserted mid-frame aborts the frame; no strobe is emitted for it.
- Synchronisation:
  - rx_Lat, rx_Dclk and rx_Di each pass through 2 flops (s1, s2), plus a third flop s3 for edge detection.
  - dclk_rise = dclk_s2 & ~dclk_s3; lat_fall = ~lat_s2 & lat_s3; lat_rise = lat_s2 & ~lat_s3.
  - Pin-to-detect latency is 3 cycles.
  - DI is sampled as di_s2 in the dclk_rise cycle. The transmitter holds DI for ≥3 cycles around each DCLK edge, which covers this.
- Shifting: on each dclk_rise, shift = {shift[14:0], di_s2}; word_cnt (4 bits) increments and wraps 15→0.
- Word output: when dclk_rise occurs with word_cnt == 15, the next cycle has rx_Word = new shift value and rx_Word_Valid = 1.
- Shifting and word output continue while LAT is high.
- Frame counter: frame_cnt increments on each dclk_rise and saturates at 1023.
- Edge counter: lat_cnt increments on dclk_rise only when lat_s2 == 1; it saturates at 31 and clears on lat_rise.
- FSM states:
  - IDLE: frame_cnt == 0 and LAT low. Go to SHIFT on dclk_rise; go to LATCH on lat_rise.
  - SHIFT: LAT low, bits arriving. Go to LATCH on lat_rise. Go to IDLE on timeout (see below).
  - LATCH: LAT high. Go to REPORT on lat_fall.
  - REPORT: lasts 1 cycle, then goes to IDLE.
- Timeout (SHIFT only): idle_cnt counts cycles since the last dclk_rise and resets on each rise.
  - When idle_cnt == TIMEOUT_CYC: pulse rx_Err, clear frame_cnt, word_cnt and shift, go to IDLE.
  - rx_Cmd_Valid is not pulsed.
- REPORT cycle outputs:
  - rx_Cmd_Valid = 1.
  - rx_Lat_Edges = lat_cnt; rx_Frame_Bits = frame_cnt; rx_Frame_Word = shift.
  - rx_Cmd = 2 if lat_cnt == CFG_EDGES; 1 if lat_cnt == GLB_EDGES; 0 if lat_cnt == 0; otherwise 3, with rx_Err = 1 in the same cycle.
  - frame_cnt and word_cnt clear to 0 on exit; shift is retained.
- Simultaneous events:
  - dclk_rise in the lat_rise cycle counts as LAT-high (lat_s2 == 1).
  - dclk_rise in the lat_fall cycle is shifted and counted in frame_cnt, but not in lat_cnt.
  - If that same rise completes a word, rx_Word_Valid and rx_Cmd_Valid may coincide.
- LAT never times out.

Test Plan:
- Reset → all outputs 0. Send 16 bits 0x0EA0, 11 of them with LAT high → rx_Word_Valid once with rx_Word = 0x0EA0; rx_Cmd_Valid with rx_Cmd = 2, rx_Lat_Edges = 11.
- 32 words of 0x00FF, LAT high over the final 3 edges → 32 rx_Word_Valid strobes each = 0x00FF; rx_Cmd = 1, rx_Frame_Bits = 512, rx_Err = 0.
- 17 bits then a LAT pulse with 0 edges → rx_Cmd = 0, rx_Lat_Edges = 0, rx_Frame_Bits = 17, one word strobe.
- LAT pulse containing 5 edges → rx_Cmd = 3, rx_Err pulses in the same cycle as rx_Cmd_Valid.
- 7 bits then DCLK idle for 1023 cycles → rx_Err pulse, no rx_Cmd_Valid. The next 16-bit frame decodes correctly from bit 0.
- RST_N low after 10 bits, then release and send a full frame → no stale strobes; the frame decodes correctly.
